// File: rtl/alb_ctrl.sv
// rtl/alb_ctrl.sv - command sequencer and register file driving a W-bit ALB.
// Loads complete in one cycle; ALB ops take IDLE->EXEC->IDLE with writeback on leaving EXEC.
module alb_ctrl #(
  parameter int W  = 10,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_ld,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic          cmd_usec,
  input  logic [W-1:0]  cmd_imm,
  output logic [W-1:0]  alb_a,
  output logic [W-1:0]  alb_b,
  output logic          alb_ci,
  output logic [2:0]    alb_mi,
  input  logic [W-1:0]  alb_f,
  input  logic          alb_co,
  input  logic          alb_vo,
  input  logic          alb_no,
  input  logic          alb_zo,
  input  logic [AW-1:0] rd_sel,
  output logic [W-1:0]  rd_data,
  output logic [3:0]    flags,
  output logic          busy,
  output logic          done
);

  localparam int NR = 1 << AW;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t        state;
  logic [W-1:0]  regs [NR];
  logic [AW-1:0] rd_q;
  logic          accept;

  assign accept  = cmd_valid && cmd_ready;
  assign rd_data = regs[rd_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      flags     <= 4'b0000;
      alb_a     <= '0;
      alb_b     <= '0;
      alb_ci    <= 1'b0;
      alb_mi    <= 3'b000;
      rd_q      <= '0;
      for (int i = 0; i < NR; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (cmd_ld) begin
              regs[cmd_rd] <= cmd_imm;
              done         <= 1'b1;
            end else begin
              // Operands are sampled here, so a just-written register is already visible.
              alb_a     <= regs[cmd_ra];
              alb_b     <= regs[cmd_rb];
              alb_mi    <= cmd_op;
              alb_ci    <= cmd_usec & flags[3];
              rd_q      <= cmd_rd;
              state     <= EXEC;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        EXEC: begin
          regs[rd_q] <= alb_f;
          flags      <= {alb_co, alb_vo, alb_no, alb_zo};
          done       <= 1'b1;
          state      <= IDLE;
          cmd_ready  <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alb_ctrl.sv
// tb/tb_alb_ctrl.sv - directed self-checking bench for alb_ctrl with a behavioural ALB.
module tb_alb_ctrl;
  localparam int W  = 10;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_ld, cmd_usec;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd, cmd_ra, cmd_rb, rd_sel;
  logic [W-1:0]  cmd_imm, alb_a, alb_b, alb_f, rd_data;
  logic          alb_ci, alb_co, alb_vo, alb_no, alb_zo, busy, done;
  logic [2:0]    alb_mi;
  logic [3:0]    flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alb_ctrl #(.W(W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ld(cmd_ld), .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra),
    .cmd_rb(cmd_rb), .cmd_usec(cmd_usec), .cmd_imm(cmd_imm),
    .alb_a(alb_a), .alb_b(alb_b), .alb_ci(alb_ci), .alb_mi(alb_mi),
    .alb_f(alb_f), .alb_co(alb_co), .alb_vo(alb_vo), .alb_no(alb_no),
    .alb_zo(alb_zo), .rd_sel(rd_sel), .rd_data(rd_data), .flags(flags),
    .busy(busy), .done(done)
  );

  // This ALB reports V as the carry into the MSB, so 0x3FF+0x001 sets V.
  logic [W-1:0] m_bx;
  logic [W:0]   m_sum;
  logic [W-1:0] m_low;
  always_comb begin
    m_bx   = (alb_mi == 3'b001 || alb_mi == 3'b010) ? ~alb_b : alb_b;
    m_sum  = {1'b0, alb_a} + {1'b0, m_bx} + (W+1)'(alb_ci);
    m_low  = {1'b0, alb_a[W-2:0]} + {1'b0, m_bx[W-2:0]} + W'(alb_ci);
    alb_f  = m_sum[W-1:0];
    alb_co = 1'b0;
    alb_vo = 1'b0;
    case (alb_mi)
      3'b000, 3'b001, 3'b010: begin
        alb_co = m_sum[W];
        alb_vo = m_low[W-1];
      end
      3'b011:         alb_f = alb_a | alb_b;
      3'b100, 3'b101: alb_f = alb_a & alb_b;
      default:        alb_f = alb_a ^ alb_b;
    endcase
    alb_no = alb_f[W-1];
    alb_zo = (alb_f == '0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] sel, input logic [W-1:0] exp);
    rd_sel = sel;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic do_load(input logic [AW-1:0] rd, input logic [W-1:0] imm);
    cmd_valid = 1'b1; cmd_ld = 1'b1; cmd_rd = rd; cmd_imm = imm;
    tick();
    cmd_valid = 1'b0; cmd_ld = 1'b0;
    chk("ld_done", done, 1);
  endtask

  task automatic do_alb(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                        input logic [AW-1:0] rb, input logic usec, input logic exp_ci);
    chk("alb_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_ld = 1'b0; cmd_op = op; cmd_rd = rd;
    cmd_ra = ra; cmd_rb = rb; cmd_usec = usec;
    tick();
    cmd_valid = 1'b0;
    chk("alb_busy_exec", busy, 1);
    chk("alb_ready_exec", cmd_ready, 0);
    chk("alb_done_exec", done, 0);
    chk("alb_ci", alb_ci, exp_ci);
    chk("alb_mi", alb_mi, op);
    tick();
    chk("alb_done", done, 1);
    chk("alb_ready_after", cmd_ready, 1);
  endtask

  logic [AW-1:0] bb_ra [3];
  int n_acc, n_done;
  int acc_cyc [3];
  logic ready_before;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_op = 3'b000; cmd_rd = '0;
    cmd_ra = '0; cmd_rb = '0; cmd_usec = 1'b0; cmd_imm = '0; rd_sel = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", flags, 4'b0000);
    chk("rst_alb_a", alb_a, 0);
    chk("rst_alb_mi", alb_mi, 0);
    for (int i = 0; i < 4; i++) rd_chk("rst_reg", AW'(i), 10'h000);

    // Load: old value visible until the write edge, new value after.
    rd_sel = 2'd0;
    cmd_valid = 1'b1; cmd_ld = 1'b1; cmd_rd = 2'd0; cmd_imm = 10'h3FF;
    #1;
    chk("ld_old_value", rd_data, 10'h000);
    tick();
    cmd_valid = 1'b0; cmd_ld = 1'b0;
    chk("ld_done_first", done, 1);
    chk("ld_new_value", rd_data, 10'h3FF);
    do_load(2'd1, 10'h001);
    rd_chk("ld_r1", 2'd1, 10'h001);
    chk("ld_flags", flags, 4'b0000);
    tick();
    chk("ld_done_clear", done, 0);

    // Wrap add
    do_alb(3'b000, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0);
    rd_chk("wrap_r2", 2'd2, 10'h000);
    chk("wrap_flags", flags, 4'b1101);

    // Chained add with carry-in from flag C
    do_alb(3'b000, 2'd3, 2'd1, 2'd1, 1'b1, 1'b1);
    rd_chk("chain_r3", 2'd3, 10'h003);
    chk("chain_flags", flags, 4'b0000);

    // Logic ops
    do_load(2'd0, 10'h2AA);
    do_load(2'd1, 10'h155);
    chk("logic_ld_flags", flags, 4'b0000);
    do_alb(3'b110, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0);
    rd_chk("xor_r2", 2'd2, 10'h3FF);
    chk("xor_flags", flags, 4'b0010);
    do_alb(3'b100, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0);
    rd_chk("and_r2", 2'd2, 10'h000);
    chk("and_flags", flags, 4'b0001);

    // Back-to-back ALB commands with cmd_valid held
    do_load(2'd0, 10'h005);
    do_load(2'd1, 10'h003);
    bb_ra[0] = 2'd0; bb_ra[1] = 2'd2; bb_ra[2] = 2'd2;
    n_acc = 0; n_done = 0;
    for (int c = 0; c < 6; c++) begin
      cmd_valid = (n_acc < 3);
      if (n_acc < 3) begin
        cmd_ld = 1'b0; cmd_op = 3'b000; cmd_rd = 2'd2;
        cmd_ra = bb_ra[n_acc]; cmd_rb = 2'd1; cmd_usec = 1'b0;
      end
      ready_before = cmd_ready;
      tick();
      if (ready_before && n_acc < 3) begin
        acc_cyc[n_acc] = c;
        n_acc++;
        chk("bb_ready_exec", cmd_ready, 0);
        chk("bb_busy_exec", busy, 1);
      end
      if (done) n_done++;
    end
    cmd_valid = 1'b0;
    chk("bb_accepts", n_acc, 3);
    chk("bb_dones", n_done, 3);
    chk("bb_space1", acc_cyc[1] - acc_cyc[0], 2);
    chk("bb_space2", acc_cyc[2] - acc_cyc[1], 2);
    rd_chk("bb_r2", 2'd2, 10'h00E);

    // Reset during EXEC
    do_load(2'd3, 10'h3FF);
    do_alb(3'b000, 2'd2, 2'd3, 2'd1, 1'b0, 1'b0);
    rd_chk("pre_rst_r2", 2'd2, 10'h002);
    chk("pre_rst_flags", flags, 4'b1100);
    cmd_valid = 1'b1; cmd_ld = 1'b0; cmd_op = 3'b000; cmd_rd = 2'd2;
    cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_usec = 1'b0;
    tick();
    cmd_valid = 1'b0;
    chk("rst_exec_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_done", done, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_flags", flags, 4'b0000);
    chk("abort_alb_a", alb_a, 0);
    for (int i = 0; i < 4; i++) rd_chk("abort_reg", AW'(i), 10'h000);
    tick();
    chk("abort_done_later", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
